// File: rtl/classifier_operand_sequencer.sv
// classifier_operand_sequencer: buffers operands, streams them to the classification network, returns its verdict
module classifier_operand_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int TIMEOUT    = 32,
    localparam int AW        = $clog2(DEPTH),
    localparam int TW        = $clog2(TIMEOUT + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  ld_valid_i,
    output logic                  ld_ready_o,
    input  logic [2:0]            ld_sel_i,
    input  logic [AW-1:0]         ld_addr_i,
    input  logic [DATA_WIDTH-1:0] ld_data_i,
    input  logic                  cmd_start_i,
    output logic                  busy_o,
    output logic                  clr_o,
    output logic                  start_o,
    output logic [DATA_WIDTH-1:0] x1j_o,
    output logic [DATA_WIDTH-1:0] x2j_o,
    output logic [DATA_WIDTH-1:0] x3j_o,
    output logic [DATA_WIDTH-1:0] wj_o,
    output logic [DATA_WIDTH-1:0] b1_o,
    input  logic                  done_i,
    input  logic                  unhealthy_i,
    output logic                  res_valid_o,
    input  logic                  res_ready_i,
    output logic                  res_unhealthy_o,
    output logic                  res_err_o,
    output logic [7:0]            run_cnt_o
);
    typedef enum logic [2:0] {S_IDLE, S_CLR, S_KICK, S_STREAM, S_WAIT, S_HOLD} state_e;

    state_e                state_q;
    logic [DATA_WIDTH-1:0] x1_q [DEPTH];
    logic [DATA_WIDTH-1:0] x2_q [DEPTH];
    logic [DATA_WIDTH-1:0] x3_q [DEPTH];
    logic [DATA_WIDTH-1:0] w_q  [DEPTH];
    logic [DATA_WIDTH-1:0] bias_q;
    logic [AW-1:0]         idx_q;
    logic [TW-1:0]         tcnt_q;
    logic [7:0]            run_cnt_q;
    logic                  res_unh_q;
    logic                  res_err_q;
    logic                  drive;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            bias_q    <= '0;
            idx_q     <= '0;
            tcnt_q    <= '0;
            run_cnt_q <= '0;
            res_unh_q <= 1'b0;
            res_err_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                x1_q[i] <= '0;
                x2_q[i] <= '0;
                x3_q[i] <= '0;
                w_q[i]  <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ld_valid_i) begin
                        if (ld_sel_i == 3'd4) bias_q <= ld_data_i;
                        else if (int'(ld_addr_i) < DEPTH) begin
                            case (ld_sel_i)
                                3'd0: x1_q[ld_addr_i] <= ld_data_i;
                                3'd1: x2_q[ld_addr_i] <= ld_data_i;
                                3'd2: x3_q[ld_addr_i] <= ld_data_i;
                                3'd3: w_q[ld_addr_i]  <= ld_data_i;
                                default: ;
                            endcase
                        end
                    end
                    if (cmd_start_i) state_q <= S_CLR;
                end
                S_CLR: state_q <= S_KICK;
                S_KICK: begin
                    idx_q   <= AW'(1);
                    state_q <= S_STREAM;
                end
                S_STREAM: begin
                    if (idx_q == AW'(DEPTH - 1)) begin
                        idx_q   <= '0;
                        tcnt_q  <= '0;
                        state_q <= S_WAIT;
                    end else idx_q <= idx_q + AW'(1);
                end
                // done takes priority over an expiring timeout in the same cycle
                S_WAIT: begin
                    if (done_i || tcnt_q == TW'(TIMEOUT - 1)) begin
                        res_unh_q <= done_i & unhealthy_i;
                        res_err_q <= !done_i;
                        run_cnt_q <= run_cnt_q + 8'd1;
                        state_q   <= S_HOLD;
                    end else tcnt_q <= tcnt_q + TW'(1);
                end
                S_HOLD: if (res_ready_i) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign drive           = (state_q == S_KICK) || (state_q == S_STREAM);
    assign x1j_o           = drive ? x1_q[idx_q] : '0;
    assign x2j_o           = drive ? x2_q[idx_q] : '0;
    assign x3j_o           = drive ? x3_q[idx_q] : '0;
    assign wj_o            = drive ? w_q[idx_q] : '0;
    assign b1_o            = bias_q;
    assign clr_o           = state_q == S_CLR;
    assign start_o         = state_q == S_KICK;
    assign busy_o          = state_q != S_IDLE;
    assign ld_ready_o      = state_q == S_IDLE;
    assign res_valid_o     = state_q == S_HOLD;
    assign res_unhealthy_o = res_unh_q;
    assign res_err_o       = res_err_q;
    assign run_cnt_o       = run_cnt_q;
endmodule

// File: tb/tb_classifier_operand_sequencer.sv
// tb_classifier_operand_sequencer: randomized runs against an operand/result model with a result scoreboard
module tb_classifier_operand_sequencer;
    localparam int DW = 16;
    localparam int D  = 8;
    localparam int TO = 32;
    localparam int AW = $clog2(D);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ld_valid = 1'b0, ld_ready;
    logic [2:0]    ld_sel = '0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_data = '0;
    logic          cmd_start = 1'b0, busy, clr, start;
    logic [DW-1:0] x1j, x2j, x3j, wj, b1;
    logic          net_done = 1'b0, junk_done = 1'b0, done, unhealthy = 1'b0;
    logic          res_valid, res_ready = 1'b0, res_unhealthy, res_err;
    logic [7:0]    run_cnt;

    assign done = net_done | junk_done;

    classifier_operand_sequencer #(.DATA_WIDTH(DW), .DEPTH(D), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .ld_valid_i(ld_valid), .ld_ready_o(ld_ready), .ld_sel_i(ld_sel),
        .ld_addr_i(ld_addr), .ld_data_i(ld_data),
        .cmd_start_i(cmd_start), .busy_o(busy), .clr_o(clr), .start_o(start),
        .x1j_o(x1j), .x2j_o(x2j), .x3j_o(x3j), .wj_o(wj), .b1_o(b1),
        .done_i(done), .unhealthy_i(unhealthy),
        .res_valid_o(res_valid), .res_ready_i(res_ready),
        .res_unhealthy_o(res_unhealthy), .res_err_o(res_err), .run_cnt_o(run_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       unh;
        logic       err;
        logic [7:0] cnt;
        int         vcyc;
    } res_t;

    res_t          sbq[$];
    int            errors = 0;
    int            checks = 0;
    logic [DW-1:0] m [4][D];
    logic [DW-1:0] mb;
    int            mcnt = 0;
    logic          last_unh = 1'b0, last_err = 1'b0;
    bit            net_resp = 1'b0, net_unh = 1'b0;
    int            net_dly = 0;
    logic          mon_pv = 1'b0;
    res_t          mon_cur;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // network: answers done a fixed number of cycles after it sees start
    initial forever begin
        @(negedge clk);
        if (start && net_resp) begin
            repeat (net_dly) @(negedge clk);
            net_done  = 1'b1;
            unhealthy = net_unh;
            @(negedge clk);
            net_done  = 1'b0;
            unhealthy = 1'b0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (res_valid && !mon_pv) begin
            if (sbq.size() == 0) chk("sb_unexpected_result", 1, 0);
            else begin
                mon_cur = sbq.pop_front();
                chk("res_cycle", 64'(cyc), 64'(mon_cur.vcyc));
                chk("res_unhealthy", res_unhealthy, mon_cur.unh);
                chk("res_err", res_err, mon_cur.err);
                chk("run_cnt", run_cnt, mon_cur.cnt);
            end
        end else if (res_valid) begin
            chk("hold_unhealthy", res_unhealthy, mon_cur.unh);
            chk("hold_err", res_err, mon_cur.err);
        end
        mon_pv = res_valid;
    end

    task automatic check_bus(input int n);
        logic [DW-1:0] e [4];
        for (int j = 0; j < 4; j++) e[j] = (n >= 2 && n <= D + 1) ? m[j][n-2] : '0;
        chk("clr", clr, n == 1);
        chk("start", start, n == 2);
        chk("busy", busy, 1);
        chk("x1j", x1j, e[0]);
        chk("x2j", x2j, e[1]);
        chk("x3j", x3j, e[2]);
        chk("wj", wj, e[3]);
        chk("b1", b1, mb);
    endtask

    task automatic load(input logic [2:0] sel, input logic [AW-1:0] a, input logic [DW-1:0] d);
        chk("load_ready", ld_ready, 1);
        ld_valid = 1'b1;
        ld_sel   = sel;
        ld_addr  = a;
        ld_data  = d;
        if (sel == 3'd4) mb = d;
        else if (sel < 3'd4) m[sel][a] = d;
        @(negedge clk);
        ld_valid = 1'b0;
    endtask

    task automatic do_run(input bit resp, input int dly, input bit unh, input bit sw, input int hold);
        res_t r;
        int   c0;
        chk("idle_ready", ld_ready, 1);
        chk("idle_busy", busy, 0);
        net_resp = resp;
        net_dly  = dly;
        net_unh  = unh;
        if (sw) begin
            ld_valid = 1'b1;
            ld_sel   = 3'd3;
            ld_addr  = '0;
            ld_data  = 16'h7FFF;
            m[3][0]  = 16'h7FFF;
        end
        cmd_start = 1'b1;
        c0 = cyc;
        mcnt++;
        r.cnt = 8'(mcnt);
        if (resp && dly >= D && dly <= D + TO - 1) begin
            r.unh = unh; r.err = 1'b0; r.vcyc = c0 + 3 + dly;
        end else begin
            r.unh = 1'b0; r.err = 1'b1; r.vcyc = c0 + D + 2 + TO;
        end
        sbq.push_back(r);
        last_unh = r.unh;
        last_err = r.err;
        @(negedge clk);
        cmd_start = 1'b0;
        ld_valid  = 1'b0;
        for (int n = 1; n <= D + 2; n++) begin
            check_bus(n);
            @(negedge clk);
        end
        for (int i = 0; i < 3 * TO && !res_valid; i++) @(negedge clk);
        if (!res_valid) chk("res_valid_wait", 0, 1);
        for (int i = 0; i < hold; i++) begin
            chk("hold_ld_ready", ld_ready, 0);
            chk("hold_pulses", {clr, start}, 0);
            cmd_start = 1'($urandom);
            ld_valid  = 1'($urandom);
            ld_sel    = 3'($urandom);
            ld_addr   = AW'($urandom);
            ld_data   = DW'($urandom);
            junk_done = 1'($urandom);
            @(negedge clk);
        end
        cmd_start = 1'b0;
        ld_valid  = 1'b0;
        junk_done = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("back_idle_valid", res_valid, 0);
        chk("back_idle_ready", ld_ready, 1);
        chk("keep_unhealthy", res_unhealthy, last_unh);
        chk("keep_err", res_err, last_err);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c0;
        for (int j = 0; j < 4; j++) for (int i = 0; i < D; i++) m[j][i] = '0;
        mb = '0;
        #12;
        chk("rst_ld_ready", ld_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_pulses", {clr, start}, 0);
        chk("rst_bus", {x1j, x2j, x3j, wj, b1}, 0);
        chk("rst_res", {res_valid, res_unhealthy, res_err}, 0);
        chk("rst_run_cnt", run_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < D; i++) begin
            load(3'd0, AW'(i), 16'h0400);
            load(3'd1, AW'(i), 16'h0800);
            load(3'd2, AW'(i), 16'hFC00);
            load(3'd3, AW'(i), 16'(16'h0200 + i));
        end
        load(3'd4, '0, 16'h0100);
        do_run(1, 21, 1, 0, 0);
        do_run(0, 0, 0, 0, 0);
        do_run(1, 15, 0, 0, 5);
        do_run(1, 10, 1, 1, 1);
        repeat (6) begin
            repeat ($urandom_range(1, 6)) load(3'($urandom_range(0, 7)), AW'($urandom), DW'($urandom));
            do_run(1'($urandom_range(0, 1)), $urandom_range(8, 39), 1'($urandom), 0, $urandom_range(0, 3));
        end
        do_run(1, 7, 1, 0, 0);
        do_run(1, 39, 1, 0, 0);
        do_run(1, 8, 1, 0, 2);

        net_resp  = 1'b0;
        cmd_start = 1'b1;
        c0 = cyc;
        @(negedge clk);
        cmd_start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_cycle", 64'(cyc), 64'(c0 + 5));
        chk("pre_rst_wj", wj, m[3][3]);
        rst_n = 1'b0;
        #1;
        chk("arst_pulses", {clr, start}, 0);
        chk("arst_bus", {x1j, x2j, x3j, wj, b1}, 0);
        chk("arst_res", {res_valid, res_unhealthy, res_err}, 0);
        chk("arst_busy_ready", {busy, ld_ready}, 2'b01);
        chk("arst_run_cnt", run_cnt, 0);
        for (int j = 0; j < 4; j++) for (int i = 0; i < D; i++) m[j][i] = '0;
        mb = '0;
        mcnt = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("post_rst_quiet", {clr, start, busy, res_valid}, 0);
            chk("post_rst_run_cnt", run_cnt, 0);
        end
        do_run(1, 12, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("sb_drained", 64'(sbq.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
